// File: rtl/port_rr_issue_if.sv
// port_rr_issue_if: request/stall inputs and issue/status outputs of the
// per-port round-robin issue stage. The DUT uses the slave modport; the
// driver of requests and consumer of issues uses the master modport.
interface port_rr_issue_if #(
  parameter int PORT_N = 20,
  parameter int PORT_W = (PORT_N == 1) ? 1 : $clog2(PORT_N)
);
  logic [PORT_N-1:0] i_req;
  logic              i_stall;
  logic              o_mem_ren;
  logic [PORT_W-1:0] o_mem_raddr;
  logic              o_port_vld;
  logic [PORT_W-1:0] o_port_id;
  logic [PORT_N-1:0] o_pend_nz;
  logic [PORT_N-1:0] o_ovf;

  modport slave (
    input  i_req,
    input  i_stall,
    output o_mem_ren,
    output o_mem_raddr,
    output o_port_vld,
    output o_port_id,
    output o_pend_nz,
    output o_ovf
  );

  modport master (
    output i_req,
    output i_stall,
    input  o_mem_ren,
    input  o_mem_raddr,
    input  o_port_vld,
    input  o_port_id,
    input  o_pend_nz,
    input  o_ovf
  );
endinterface

// File: rtl/port_rr_issue.sv
// port_rr_issue: upstream issue stage of the per-port read-modify-write pipe.
// Per-port request pulses accumulate in saturating pending counters. Each
// unstalled cycle one port with a nonzero count is granted round-robin; the
// grant drives the memory read combinationally and the registered issue
// (o_port_vld/o_port_id) follows one cycle later, aligned with read data.
// Optional feature macro: STICKY_GRANT_EN -- keep granting the same port for
// up to MAX_BURST consecutive grants while it still has pending work.
module port_rr_issue #(
  parameter int PORT_N    = 20,
  parameter int PORT_W    = (PORT_N == 1) ? 1 : $clog2(PORT_N),
  parameter int CNT_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  port_rr_issue_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [PORT_W-1:0] LAST_ID = PORT_W'(PORT_N - 1);

  logic [CNT_W-1:0]  r_pend [PORT_N];
  logic [PORT_W-1:0] r_rr_ptr;
  logic [PORT_W-1:0] r_raddr;
  logic              r_port_vld;
  logic [PORT_W-1:0] r_port_id;
  logic [PORT_N-1:0] r_pend_nz;
  logic [PORT_N-1:0] r_ovf;

  logic [PORT_N-1:0] w_elig;
  logic [PORT_N-1:0] w_elig_hi;
  logic              w_any;
  logic              w_any_hi;
  logic [PORT_W-1:0] w_hi_id;
  logic [PORT_W-1:0] w_lo_id;
  logic [PORT_W-1:0] w_rr_id;
  logic              w_gnt;
  logic [PORT_W-1:0] w_gnt_id;
  logic [PORT_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0]  w_pend_nxt [PORT_N];
  logic [PORT_N-1:0] w_nz_nxt;
  logic [PORT_N-1:0] w_ovf_nxt;

  // Eligibility from registered counts only; split at the rr pointer.
  always_comb begin
    for (int p = 0; p < PORT_N; p++) begin
      w_elig[p]    = (r_pend[p] != '0);
      w_elig_hi[p] = w_elig[p] && (PORT_W'(p) >= r_rr_ptr);
    end
  end

  // Round-robin pick: lowest eligible at/above pointer, else lowest overall.
  always_comb begin
    w_hi_id  = '0;
    w_lo_id  = '0;
    w_any    = |w_elig;
    w_any_hi = |w_elig_hi;
    for (int p = PORT_N - 1; p >= 0; p--) begin
      if (w_elig_hi[p]) w_hi_id = PORT_W'(p);
      if (w_elig[p])    w_lo_id = PORT_W'(p);
    end
    w_rr_id = w_any_hi ? w_hi_id : w_lo_id;
  end

`ifdef STICKY_GRANT_EN
  localparam int BURST_W = 4;

  logic               r_sticky;
  logic [PORT_W-1:0]  r_last_id;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] w_burst_nxt;
  logic [CNT_W-1:0]   w_gnt_pend_nxt;
  logic               w_stick_hold;

  // A running burst overrides round-robin; r_sticky implies pending != 0.
  always_comb begin
    w_gnt       = !bus.i_stall && (r_sticky || w_any);
    w_gnt_id    = r_sticky ? r_last_id : w_rr_id;
    w_burst_nxt = r_sticky ? r_burst_cnt + 1'b1 : BURST_W'(1);
  end

  // Burst continues while the granted port keeps work and has budget left;
  // the pointer only moves past the port once the burst ends.
  always_comb begin
    w_gnt_pend_nxt = '0;
    for (int p = 0; p < PORT_N; p++) begin
      if (PORT_W'(p) == w_gnt_id) w_gnt_pend_nxt = w_pend_nxt[p];
    end
    w_stick_hold = (w_gnt_pend_nxt != '0) && (w_burst_nxt < BURST_W'(MAX_BURST));
    w_ptr_nxt    = r_rr_ptr;
    if (w_gnt && !w_stick_hold) begin
      w_ptr_nxt = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Burst tracking state; a stall cycle leaves it untouched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky    <= 1'b0;
      r_last_id   <= '0;
      r_burst_cnt <= '0;
    end else if (w_gnt) begin
      r_sticky    <= w_stick_hold;
      r_last_id   <= w_gnt_id;
      r_burst_cnt <= w_burst_nxt;
    end
  end
`else
  // Strict round-robin: grant the picked port, pointer moves past it.
  always_comb begin
    w_gnt     = !bus.i_stall && w_any;
    w_gnt_id  = w_rr_id;
    w_ptr_nxt = r_rr_ptr;
    if (w_gnt) begin
      w_ptr_nxt = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
    end
  end
`endif

  // Per-port counter update: request adds, grant subtracts, both cancel;
  // a request that finds the counter saturated is dropped and flagged.
  always_comb begin
    for (int p = 0; p < PORT_N; p++) begin
      w_pend_nxt[p] = r_pend[p];
      w_ovf_nxt[p]  = 1'b0;
      if (bus.i_req[p] && !(w_gnt && (w_gnt_id == PORT_W'(p)))) begin
        if (r_pend[p] == CNT_MAX) begin
          w_ovf_nxt[p] = 1'b1;
        end else begin
          w_pend_nxt[p] = r_pend[p] + 1'b1;
        end
      end else if (!bus.i_req[p] && w_gnt && (w_gnt_id == PORT_W'(p))) begin
        w_pend_nxt[p] = r_pend[p] - 1'b1;
      end
      w_nz_nxt[p] = (w_pend_nxt[p] != '0);
    end
  end

  // Counters, pointer, issue registers and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < PORT_N; p++) r_pend[p] <= '0;
      r_rr_ptr   <= '0;
      r_raddr    <= '0;
      r_port_vld <= 1'b0;
      r_port_id  <= '0;
      r_pend_nz  <= '0;
      r_ovf      <= '0;
    end else begin
      for (int p = 0; p < PORT_N; p++) r_pend[p] <= w_pend_nxt[p];
      r_rr_ptr   <= w_ptr_nxt;
      r_port_vld <= w_gnt;
      r_pend_nz  <= w_nz_nxt;
      r_ovf      <= w_ovf_nxt;
      if (w_gnt) begin
        r_raddr   <= w_gnt_id;
        r_port_id <= w_gnt_id;
      end
    end
  end

  assign bus.o_mem_ren   = w_gnt;
  assign bus.o_mem_raddr = w_gnt ? w_gnt_id : r_raddr;
  assign bus.o_port_vld  = r_port_vld;
  assign bus.o_port_id   = r_port_id;
  assign bus.o_pend_nz   = r_pend_nz;
  assign bus.o_ovf       = r_ovf;

endmodule

// File: tb/tb_port_rr_issue.sv
// Testbench for port_rr_issue: a behavioural model keeps per-port pending
// counts as integers and picks grants by scanning ports from the pointer
// with modulo arithmetic; each scenario task compares DUT outputs inline.
module tb_port_rr_issue;
  localparam int PORT_N    = 20;
  localparam int PORT_W    = 5;
  localparam int CNT_W     = 4;
  localparam int MAX_BURST = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  port_rr_issue_if #(.PORT_N(PORT_N), .PORT_W(PORT_W)) bus ();

  port_rr_issue #(
    .PORT_N(PORT_N), .PORT_W(PORT_W), .CNT_W(CNT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_pend [PORT_N];
  int m_ptr;
  int m_stick;
  int m_burst;
  int accepted;
  int issued;
  logic [PORT_W-1:0] m_raddr;
  logic [PORT_W-1:0] m_id;

  // expected and sampled values for the current cycle
  logic              e_ren, s_ren, e_vld, s_vld;
  logic [PORT_W-1:0] e_raddr, s_raddr, e_id, s_id;
  logic [PORT_N-1:0] e_nz, s_nz, e_ovf, s_ovf;

  task automatic model_reset();
    for (int p = 0; p < PORT_N; p++) m_pend[p] = 0;
    m_ptr = 0; m_stick = -1; m_burst = 0;
    m_raddr = '0; m_id = '0;
    accepted = 0; issued = 0;
    e_vld = 1'b0; e_id = '0; e_nz = '0; e_ovf = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = '0;
    bus.i_stall = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, sample the combinational grant mid-cycle,
  // then step the model across the edge and sample registered outputs.
  task automatic cycle(input logic [PORT_N-1:0] req, input logic stall);
    bit gnt;
    int g;
    gnt = 1'b0; g = 0;
    bus.i_req = req;
    bus.i_stall = stall;
    if (!stall) begin
`ifdef STICKY_GRANT_EN
      if (m_stick >= 0) begin gnt = 1'b1; g = m_stick; end
`endif
      for (int k = 0; k < PORT_N; k++) begin
        if (!gnt && m_pend[(m_ptr + k) % PORT_N] > 0) begin
          gnt = 1'b1; g = (m_ptr + k) % PORT_N;
        end
      end
    end
    e_ren = gnt;
    if (gnt) m_raddr = PORT_W'(g);
    e_raddr = m_raddr;
    @(negedge clk);
    s_ren = bus.o_mem_ren; s_raddr = bus.o_mem_raddr;
    @(posedge clk); #1;
    e_ovf = '0;
    for (int p = 0; p < PORT_N; p++) begin
      bit dec;
      dec = gnt && (g == p);
      if (req[p] && dec) accepted++;
      else if (req[p]) begin
        if (m_pend[p] == CMAX) e_ovf[p] = 1'b1;
        else begin m_pend[p]++; accepted++; end
      end else if (dec) m_pend[p]--;
    end
    if (gnt) begin
      issued++;
      m_id = PORT_W'(g);
`ifdef STICKY_GRANT_EN
      m_burst = (m_stick == g) ? m_burst + 1 : 1;
      if (m_pend[g] > 0 && m_burst < MAX_BURST) m_stick = g;
      else begin m_stick = -1; m_ptr = (g + 1) % PORT_N; end
`else
      m_ptr = (g + 1) % PORT_N;
`endif
    end
    e_vld = gnt;
    e_id = m_id;
    for (int p = 0; p < PORT_N; p++) e_nz[p] = (m_pend[p] != 0);
    s_vld = bus.o_port_vld; s_id = bus.o_port_id;
    s_nz = bus.o_pend_nz; s_ovf = bus.o_ovf;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(PORT_N'(1) << 15, 1'b0);
    cycle('0, 1'b0);                       // grants 15, pointer now 16
    cycle((PORT_N'(1) << 2) | (PORT_N'(1) << 10), 1'b0);
    rst = 1'b1; #2;
    n_checks++;
    if (bus.o_port_vld !== 1'b0 || bus.o_port_id !== '0) begin
      n_fail++; $display("FAIL reset_issue vld=%0b id=%0d want 0/0", bus.o_port_vld, bus.o_port_id);
    end
    n_checks++;
    if (bus.o_pend_nz !== '0 || bus.o_ovf !== '0 || bus.o_mem_ren !== 1'b0) begin
      n_fail++; $display("FAIL reset_status nz=%h ovf=%h ren=%0b want 0", bus.o_pend_nz, bus.o_ovf, bus.o_mem_ren);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle((PORT_N'(1) << 2) | (PORT_N'(1) << 17), 1'b0);
    cycle('0, 1'b0);
    n_checks++;
    if (s_ren !== 1'b1 || s_raddr !== PORT_W'(2)) begin
      n_fail++; $display("FAIL reset_ptr ren=%0b raddr=%0d want 1/2", s_ren, s_raddr);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(PORT_N'(1) << 5, 1'b0);
    n_checks++;
    if (s_ren !== 1'b0) begin
      n_fail++; $display("FAIL single_nobypass ren=%0b want 0", s_ren);
    end
    n_checks++;
    if (s_vld !== 1'b0 || s_nz[5] !== 1'b1) begin
      n_fail++; $display("FAIL single_pend vld=%0b nz5=%0b want 0/1", s_vld, s_nz[5]);
    end
    cycle('0, 1'b0);
    n_checks++;
    if (s_ren !== 1'b1 || s_raddr !== PORT_W'(5)) begin
      n_fail++; $display("FAIL single_read ren=%0b raddr=%0d want 1/5", s_ren, s_raddr);
    end
    n_checks++;
    if (s_vld !== 1'b1 || s_id !== PORT_W'(5) || s_nz[5] !== 1'b0) begin
      n_fail++; $display("FAIL single_issue vld=%0b id=%0d nz5=%0b want 1/5/0", s_vld, s_id, s_nz[5]);
    end
    cycle('0, 1'b0);
    n_checks++;
    if (s_vld !== 1'b0 || s_ren !== 1'b0) begin
      n_fail++; $display("FAIL single_idle vld=%0b ren=%0b want 0/0", s_vld, s_ren);
    end
  endtask

  task automatic test_rr_order();
    int got [$];
    int want [4] = '{2, 7, 19, 0};
    do_reset();
    cycle((PORT_N'(1) << 2) | (PORT_N'(1) << 7) | (PORT_N'(1) << 19), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b0);
      if (s_vld) got.push_back(int'(s_id));
    end
    cycle(PORT_N'(1), 1'b0);
    if (s_vld) got.push_back(int'(s_id));
    cycle('0, 1'b0);
    if (s_vld) got.push_back(int'(s_id));
    n_checks++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL rr_count got=%0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] != want[i]) begin
          n_fail++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    int ovf_cnt = 0;
    int ren_cnt = 0;
    int iss3 = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(PORT_N'(1) << 3, 1'b1);
      if (s_ovf[3]) ovf_cnt++;
      if (s_ren) ren_cnt++;
    end
    n_checks++;
    if (ovf_cnt != 1 || ren_cnt != 0) begin
      n_fail++; $display("FAIL sat_ovf pulses=%0d grants=%0d want 1/0", ovf_cnt, ren_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      cycle('0, 1'b0);
      if (s_vld && s_id == PORT_W'(3)) iss3++;
    end
    n_checks++;
    if (iss3 != 15 || s_nz[3] !== 1'b0) begin
      n_fail++; $display("FAIL sat_drain issues=%0d nz3=%0b want 15/0", iss3, s_nz[3]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    cycle(PORT_N'(1) << 4, 1'b0);
    cycle(PORT_N'(1) << 4, 1'b0);
    n_checks++;
    if (s_vld !== 1'b1 || s_id !== PORT_W'(4) || s_nz[4] !== 1'b1) begin
      n_fail++; $display("FAIL same_hold vld=%0b id=%0d nz4=%0b want 1/4/1", s_vld, s_id, s_nz[4]);
    end
    cycle('0, 1'b0);
    n_checks++;
    if (s_vld !== 1'b1 || s_id !== PORT_W'(4) || s_nz[4] !== 1'b0) begin
      n_fail++; $display("FAIL same_again vld=%0b id=%0d nz4=%0b want 1/4/0", s_vld, s_id, s_nz[4]);
    end
  endtask

  task automatic test_stall_toggle();
    logic [PORT_N-1:0] r3;
    logic st;
    int acc0;
    r3 = (PORT_N'(1) << 1) | (PORT_N'(1) << 6) | (PORT_N'(1) << 9);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(r3, 1'b1);
    acc0 = issued;
    for (int i = 0; i < 16; i++) begin
      st = (i < 6) ? ((i % 2) == 0) : 1'b0;
      cycle('0, st);
      if (st) begin
        n_checks++;
        if (s_vld !== 1'b0 || s_ren !== 1'b0) begin
          n_fail++; $display("FAIL stall_vld cyc=%0d vld=%0b ren=%0b want 0/0", i, s_vld, s_ren);
        end
      end else if (i < 8) begin
        n_checks++;
        if (s_vld !== 1'b1) begin
          n_fail++; $display("FAIL stall_issue cyc=%0d vld=%0b want 1", i, s_vld);
        end
      end
    end
    n_checks++;
    if (issued - acc0 != 9 || accepted != 9 || s_nz !== '0) begin
      n_fail++; $display("FAIL stall_total issued=%0d accepted=%0d nz=%h want 9/9/0", issued - acc0, accepted, s_nz);
    end
  endtask

  task automatic test_random();
    logic [PORT_N-1:0] rq;
    logic st;
    int nf0 = n_fail;
    do_reset();
    for (int c = 0; c < 720; c++) begin
      if (c < 400) begin
        rq = PORT_N'($urandom & $urandom & $urandom);
        st = ($urandom_range(0, 3) == 0);
      end else begin
        rq = '0;
        st = 1'b0;
      end
      cycle(rq, st);
      if (n_fail - nf0 < 10) begin
        n_checks++;
        if (s_ren !== e_ren || s_raddr !== e_raddr) begin
          n_fail++; $display("FAIL rand_read cyc=%0d ren=%0b raddr=%0d want %0b/%0d", c, s_ren, s_raddr, e_ren, e_raddr);
        end
        n_checks++;
        if (s_vld !== e_vld || s_id !== e_id) begin
          n_fail++; $display("FAIL rand_issue cyc=%0d vld=%0b id=%0d want %0b/%0d", c, s_vld, s_id, e_vld, e_id);
        end
        n_checks++;
        if (s_nz !== e_nz || s_ovf !== e_ovf) begin
          n_fail++; $display("FAIL rand_status cyc=%0d nz=%h ovf=%h want %h/%h", c, s_nz, s_ovf, e_nz, e_ovf);
        end
      end
    end
    n_checks++;
    if (issued != accepted || s_nz !== '0) begin
      n_fail++; $display("FAIL rand_total issued=%0d accepted=%0d nz=%h", issued, accepted, s_nz);
    end
  endtask

  task automatic test_burst();
    int got [$];
`ifdef STICKY_GRANT_EN
    int want [7] = '{1, 1, 1, 1, 2, 1, 1};
`else
    int want [7] = '{1, 2, 1, 1, 1, 1, 1};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) cycle(PORT_N'(1) << 1, 1'b1);
    cycle(PORT_N'(1) << 2, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle('0, 1'b0);
      if (s_vld) got.push_back(int'(s_id));
    end
    n_checks++;
    if (got.size() != 7) begin
      n_fail++; $display("FAIL burst_count got=%0d want 7", got.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (got[i] != want[i]) begin
          n_fail++; $display("FAIL burst_seq idx=%0d got=%0d want=%0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  initial begin
    bus.i_req = '0;
    bus.i_stall = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_rr_order();
    test_saturate();
    test_same_cycle();
    test_stall_toggle();
    test_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
